// File: rtl/pll_dyn_ctrl_pkg.sv
// Shared types for the PLL dynamic-phase controller: FSM state encoding and
// PLL phasesel output codes, plus the channel-index to phasesel mapping.
package pll_dyn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_IDLE      = 3'd2,
    ST_SETUP     = 3'd3,
    ST_STEP_HI   = 3'd4,
    ST_STEP_LO   = 3'd5,
    ST_LOAD      = 3'd6
  } state_e;

  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;
  localparam logic [1:0] SEL_CLKOP  = 2'b11;

  // Channel 0 is the primary output CLKOP; the secondaries follow in order.
  function automatic logic [1:0] ch_to_sel(input logic [1:0] ch);
    logic [1:0] sel;
    case (ch)
      2'd0:    sel = SEL_CLKOP;
      2'd1:    sel = SEL_CLKOS;
      2'd2:    sel = SEL_CLKOS2;
      default: sel = SEL_CLKOS3;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Two-flop synchroniser for the raw PLL lock plus the continuous-lock counter
// that qualifies it while the controller waits for lock.
module pll_lock_filter #(
  parameter int LOCK_FILT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic pll_lock_i,
  input  logic enable,
  output logic lock_sync,
  output logic filt_done
);

  localparam int CW = $clog2(LOCK_FILT + 1);

  logic          sync_q1;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q1   <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      sync_q1   <= pll_lock_i;
      lock_sync <= sync_q1;
    end
  end

  // Any low sample restarts the count; the count is idle outside WAIT_LOCK.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (!enable || !lock_sync) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign filt_done = enable && lock_sync && (cnt_q == CW'(LOCK_FILT - 1));

endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL reset/lock sequencing and dynamic phase-step controller.
// Define PLL_DYN_CTRL_RELOCK_EN to re-run the reset/lock sequence on lock loss.
module pll_dyn_ctrl
  import pll_dyn_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int RST_CYCLES = 8,
  parameter int LOCK_FILT  = 16,
  parameter int STEP_PULSE = 4,
  parameter int SETTLE     = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock_i,
  output logic       pll_rst_o,
  output logic       locked_o,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_ch,
  input  logic       req_dir,
  input  logic [3:0] req_steps,
  output logic [1:0] phasesel_o,
  output logic       phasedir_o,
  output logic       phasestep_o,
  output logic       phaseloadreg_o,
  output logic       busy_o,
  output logic       err_ch_o,
  output logic       lock_lost_o,
  output logic [2:0] state_dbg
);

  localparam int RCW   = $clog2(RST_CYCLES + 1);
  localparam int PMAX  = (STEP_PULSE > SETTLE) ? STEP_PULSE : SETTLE;
  localparam int PCW   = $clog2(PMAX + 1);

  state_e         state_q, state_d;
  logic [RCW-1:0] rst_cnt_q;
  logic [PCW-1:0] ph_cnt_q;
  logic [3:0]     steps_q;
  logic           lock_sync, filt_done;
  logic           lock_loss, xfer, ch_bad, good_req;

  pll_lock_filter #(.LOCK_FILT(LOCK_FILT)) u_lock_filter (
    .clk        (clk),
    .resetn     (resetn),
    .pll_lock_i (pll_lock_i),
    .enable     (state_q == ST_WAIT_LOCK),
    .lock_sync  (lock_sync),
    .filt_done  (filt_done)
  );

  assign lock_loss = !lock_sync && (state_q != ST_RST) && (state_q != ST_WAIT_LOCK);
  // Handshake: a request transfers on any edge where req_valid && req_ready;
  // req_valid may be held across busy periods and is taken on the first IDLE cycle.
  assign xfer      = req_valid && req_ready;
  assign ch_bad    = int'(req_ch) >= NUM_CH;
  assign good_req  = xfer && !ch_bad && (req_steps != 4'd0);
  assign state_dbg = state_q;

  always_comb begin
    state_d        = state_q;
    pll_rst_o      = (state_q == ST_RST);
    busy_o         = (state_q != ST_IDLE);
    phasestep_o    = (state_q == ST_STEP_HI);
    phaseloadreg_o = (state_q == ST_LOAD);
`ifdef PLL_DYN_CTRL_RELOCK_EN
    req_ready      = (state_q == ST_IDLE) && !lock_loss;
`else
    req_ready      = (state_q == ST_IDLE);
`endif
    case (state_q)
      ST_RST:       if (rst_cnt_q == RCW'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (filt_done) state_d = ST_IDLE;
      ST_IDLE:      if (good_req) state_d = ST_SETUP;
      ST_SETUP:     state_d = ST_STEP_HI;
      ST_STEP_HI:   if (ph_cnt_q == PCW'(STEP_PULSE - 1)) state_d = ST_STEP_LO;
      ST_STEP_LO:   if (ph_cnt_q == PCW'(SETTLE - 1))
                      state_d = (steps_q == 4'd1) ? ST_LOAD : ST_STEP_HI;
      ST_LOAD:      state_d = ST_IDLE;
      default:      state_d = ST_RST;
    endcase
`ifdef PLL_DYN_CTRL_RELOCK_EN
    if (lock_loss) state_d = ST_RST;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_RST;
    else         state_q <= state_d;
  end

  // Both counters restart whenever the state changes, so a re-entered RST
  // or a new step phase always begins from zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_cnt_q <= '0;
      ph_cnt_q  <= '0;
    end else begin
      rst_cnt_q <= (state_q == ST_RST && state_d == ST_RST) ? rst_cnt_q + RCW'(1) : '0;
      ph_cnt_q  <= (state_d == state_q && (state_q == ST_STEP_HI || state_q == ST_STEP_LO))
                   ? ph_cnt_q + PCW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      steps_q    <= 4'd0;
      phasesel_o <= SEL_CLKOP;
      phasedir_o <= 1'b0;
    end else if (good_req) begin
      steps_q    <= req_steps;
      phasesel_o <= ch_to_sel(req_ch);
      phasedir_o <= req_dir;
    end else if (state_q == ST_STEP_LO && state_d != ST_STEP_LO) begin
      steps_q    <= steps_q - 4'd1;
    end
  end

  // A loss edge that also re-enters RST keeps lock_lost_o set so the cause stays visible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      locked_o    <= 1'b0;
      lock_lost_o <= 1'b0;
      err_ch_o    <= 1'b0;
    end else begin
      err_ch_o <= xfer && ch_bad;
      if (lock_loss) begin
        locked_o    <= 1'b0;
        lock_lost_o <= 1'b1;
      end else begin
        if (filt_done) locked_o <= 1'b1;
        if (state_d == ST_RST && state_q != ST_RST) lock_lost_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl: reset/lock timing, phase-step waveforms
// against a cycle-index model, bad-channel and zero-step requests, lock loss.
module tb_pll_dyn_ctrl;

  localparam int NUM_CH     = 3;
  localparam int RST_CYCLES = 8;
  localparam int LOCK_FILT  = 16;
  localparam int STEP_PULSE = 4;
  localparam int SETTLE     = 8;
  localparam int PER        = STEP_PULSE + SETTLE;

  logic       clk, resetn, pll_lock_i;
  logic       pll_rst_o, locked_o, req_valid, req_ready, req_dir;
  logic [1:0] req_ch, phasesel_o;
  logic [3:0] req_steps;
  logic       phasedir_o, phasestep_o, phaseloadreg_o, busy_o, err_ch_o, lock_lost_o;
  logic [2:0] state_dbg;

  int         n_checks, n_pass;
  logic [1:0] code_tab [4];
  logic [1:0] m_sel;
  logic       m_dir, m_locked, m_lost;

  pll_dyn_ctrl #(
    .NUM_CH(NUM_CH), .RST_CYCLES(RST_CYCLES), .LOCK_FILT(LOCK_FILT),
    .STEP_PULSE(STEP_PULSE), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .resetn(resetn), .pll_lock_i(pll_lock_i), .pll_rst_o(pll_rst_o),
    .locked_o(locked_o), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_dir(req_dir), .req_steps(req_steps),
    .phasesel_o(phasesel_o), .phasedir_o(phasedir_o), .phasestep_o(phasestep_o),
    .phaseloadreg_o(phaseloadreg_o), .busy_o(busy_o), .err_ch_o(err_ch_o),
    .lock_lost_o(lock_lost_o), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_reset_outputs(input string tag);
    logic [10:0] obs;
    obs = {pll_rst_o, busy_o, req_ready, phasestep_o, phaseloadreg_o, err_ch_o,
           lock_lost_o, locked_o, phasedir_o, phasesel_o};
    n_checks++;
    if (obs !== 11'b11000000011) $display("FAIL %s: outputs %b expected %b", tag, obs, 11'b11000000011);
    else n_pass++;
  endtask

  task automatic hold_reset();
    resetn = 1'b0;
    pll_lock_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Releases reset and measures RST length and lock rise against the lock-timing rule.
  task automatic run_lockup(input int glitch_at, input string tag);
    int rst_hi, first_lock, last_low, exp_lock, activity;
    logic [5:0] obs;
    m_sel = 2'b11; m_dir = 1'b0; m_locked = 1'b0; m_lost = 1'b0;
    rst_hi = 0; first_lock = -1; activity = 0;
    last_low = (glitch_at > 0) ? glitch_at + 2 : 1;
    exp_lock = ((RST_CYCLES > last_low + 1) ? RST_CYCLES : last_low + 1) + LOCK_FILT;
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (glitch_at > 0 && i == glitch_at) pll_lock_i = 1'b0;
      if (glitch_at > 0 && i == glitch_at + 1) pll_lock_i = 1'b1;
      if (pll_rst_o) rst_hi++;
      if (phaseloadreg_o || phasestep_o) activity++;
      if (locked_o === 1'b1) begin
        first_lock = i;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (rst_hi != RST_CYCLES) $display("FAIL %s_rst_len: got %0d expected %0d", tag, rst_hi, RST_CYCLES);
    else n_pass++;
    n_checks++;
    if (first_lock != exp_lock) $display("FAIL %s_lock_cycle: got %0d expected %0d", tag, first_lock, exp_lock);
    else n_pass++;
    n_checks++;
    if (activity != 0) $display("FAIL %s_no_phase: got %0d expected 0", tag, activity);
    else n_pass++;
    obs = {busy_o, req_ready, lock_lost_o, phasesel_o, phasedir_o};
    n_checks++;
    if (obs !== 6'b010110) $display("FAIL %s_idle: outputs %b expected 010110", tag, obs);
    else n_pass++;
    m_locked = 1'b1;
  endtask

  // Issues one request and checks every output each cycle against the index model.
  task automatic do_req(input logic [1:0] ch, input logic dir, input logic [3:0] steps,
                        input int drop_at, input string tag);
    logic bad_ch, good;
    int n_busy;
    logic [9:0] obs, exp;
    bad_ch = int'(ch) >= NUM_CH;
    good   = !bad_ch && (steps != 4'd0);
    n_busy = good ? 2 + int'(steps) * PER : 0;
    req_valid = 1'b1; req_ch = ch; req_dir = dir; req_steps = steps;
    @(posedge clk); #1;
    req_valid = 1'b0; req_ch = 2'($urandom); req_dir = 1'($urandom); req_steps = 4'($urandom);
    if (good) begin
      m_sel = code_tab[ch];
      m_dir = dir;
    end
    for (int k = 1; k <= n_busy + 2; k++) begin
      if (drop_at > 0 && k == drop_at) pll_lock_i = 1'b0;
      if (drop_at > 0 && k == drop_at + 2) pll_lock_i = 1'b1;
      if (drop_at > 0 && k == drop_at + 3) begin
        m_lost = 1'b1;
        m_locked = 1'b0;
      end
      exp = {k <= n_busy, k > n_busy,
             good && k >= 2 && k <= 1 + int'(steps) * PER && ((k - 2) % PER) < STEP_PULSE,
             good && k == n_busy, bad_ch && k == 1, m_sel, m_dir, m_lost, m_locked};
      obs = {busy_o, req_ready, phasestep_o, phaseloadreg_o, err_ch_o,
             phasesel_o, phasedir_o, lock_lost_o, locked_o};
      n_checks++;
      if (obs !== exp) $display("FAIL %s k=%0d: outputs %b expected %b", tag, k, obs, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_ch = 2'd3; req_steps = 4'd5;
    check_reset_outputs("reset_hold");
    @(posedge clk); #1;
    check_reset_outputs("reset_hold_clk");
    req_valid = 1'b0;
  endtask

  task automatic test_lock_up();
    run_lockup(0, "lockup");
  endtask

  task automatic test_step_basic();
    do_req(2'd1, 1'b1, 4'd3, 0, "step_ch1_lag3");
    do_req(2'd0, 1'b0, 4'd1, 0, "step_ch0_lead1");
  endtask

  task automatic test_bad_channel();
    do_req(2'd3, 1'b1, 4'd4, 0, "bad_ch3");
  endtask

  task automatic test_zero_steps();
    do_req(2'd2, 1'b1, 4'd0, 0, "zero_steps");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      do_req(2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 5)), 0,
             $sformatf("rand%0d", n));
  endtask

  task automatic test_back_to_back();
    do_req(2'd2, 1'b1, 4'd2, 0, "b2b_a");
    do_req(2'd2, 1'b0, 4'd1, 0, "b2b_b");
  endtask

  task automatic test_lock_loss();
`ifdef PLL_DYN_CTRL_RELOCK_EN
    int loads, rst_seen;
    loads = 0; rst_seen = 0;
    req_valid = 1'b1; req_ch = 2'd0; req_dir = 1'b0; req_steps = 4'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (k == 14) pll_lock_i = 1'b0;
      if (k == 16) pll_lock_i = 1'b1;
      if (phaseloadreg_o) loads++;
      if (pll_rst_o) rst_seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (loads != 0) $display("FAIL relock_no_load: got %0d expected 0", loads);
    else n_pass++;
    n_checks++;
    if (rst_seen != RST_CYCLES) $display("FAIL relock_rst_len: got %0d expected %0d", rst_seen, RST_CYCLES);
    else n_pass++;
    n_checks++;
    if (locked_o !== 1'b1) $display("FAIL relock_locked: got %b expected 1", locked_o);
    else n_pass++;
`else
    do_req(2'd0, 1'b0, 4'd3, 14, "lock_loss");
    do_req(2'd1, 1'b1, 4'd1, 0, "after_loss");
`endif
  endtask

  task automatic test_reset_mid_step();
    hold_reset();
    run_lockup(0, "pre_mid");
    req_valid = 1'b1; req_ch = 2'd2; req_dir = 1'b1; req_steps = 4'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_step_reset");
    repeat (2) @(posedge clk);
    #1;
    run_lockup(0, "post_mid");
  endtask

  task automatic test_lock_glitch();
    hold_reset();
    run_lockup(18, "glitch");
  endtask

  initial begin
    code_tab[0] = 2'b11; code_tab[1] = 2'b00; code_tab[2] = 2'b01; code_tab[3] = 2'b10;
    n_checks = 0; n_pass = 0;
    req_valid = 1'b0; req_ch = 2'd0; req_dir = 1'b0; req_steps = 4'd0;
    hold_reset();
    test_reset();
    test_lock_up();
    test_step_basic();
    test_bad_channel();
    test_zero_steps();
    test_random();
    test_back_to_back();
    test_lock_loss();
    test_reset_mid_step();
    test_lock_glitch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
